// File: rtl/neuron_cfg_dispatcher.sv
// Byte-serial configuration dispatcher: buffers host frames [ID][LEN][payload] and replays
// each payload byte onto the shared data bus with a per-neuron (or broadcast) load strobe.
module neuron_cfg_dispatcher #(
  parameter int unsigned NUM_NEURONS   = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [NUM_NEURONS-1:0] load_data,
  output logic [7:0]             data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TMR_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_LOAD,
    ST_STB_HI,
    ST_STB_LO,
    ST_END
  } state_t;

  // Input byte FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]       fifo_head;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q];
  assign count_d    = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // Frame sequencer
  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic                 inv_q, inv_d;
  logic [NUM_NEURONS-1:0] load_q, load_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      inv_q   <= 1'b0;
      load_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      inv_q   <= inv_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    inv_d    = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_GET_LEN;
          if (32'(fifo_head) < NUM_NEURONS) begin
            mask_d = NUM_NEURONS'(1) << fifo_head;
            inv_d  = 1'b0;
          end else if (fifo_head == 8'hFF) begin
            mask_d = '1;
            inv_d  = 1'b0;
          end else begin
            mask_d = '0;
            inv_d  = 1'b1;
          end
        end
      end
      ST_GET_LEN: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cnt_d    = fifo_head;
          state_d  = (fifo_head == 8'd0) ? ST_END : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (inv_q) begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? ST_END : ST_LOAD;
          end else begin
            data_d  = fifo_head;
            tmr_d   = '0;
            state_d = ST_STB_HI;
          end
        end
      end
      ST_STB_HI: begin
        if (tmr_q == TMR_W'(STROBE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_STB_LO;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_STB_LO: begin
        if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
          tmr_d   = '0;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? ST_END : ST_LOAD;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobe trails STB_HI by one cycle so data settles a full cycle before the rising edge
    load_d = (state_q == ST_STB_HI) ? mask_q : '0;
    done_d = (state_q == ST_END) && !inv_q;
    err_d  = (state_q == ST_END) && inv_q;
    busy_d = (state_d != ST_IDLE);
  end

  assign in_ready   = in_ready_q;
  assign load_data  = load_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_neuron_cfg_dispatcher.sv
// Self-checking bench for neuron_cfg_dispatcher: a frame-level model predicts strobe
// (mask, byte) sequences and frame outcomes; a negedge monitor checks the bus against it.
module tb_neuron_cfg_dispatcher;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned STB   = 2;
  localparam int unsigned GAP   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic [N-1:0] load_data;
  logic [7:0]   data;
  logic         busy, frame_done, frame_err;

  neuron_cfg_dispatcher #(
    .NUM_NEURONS(N), .FIFO_DEPTH(DEPTH), .STROBE_CYCLES(STB), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_data(load_data), .data(data), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] mask; logic [7:0] dat; } stb_t;
  typedef struct { bit err; int n; } res_t;

  stb_t       exp_q[$];
  res_t       exp_res[$];
  logic [7:0] frm[$];
  int         rise_times[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc = 0, rise_total = 0;
  bit         saw_full = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Bus monitor
  logic [N-1:0] prev_ld = '0;
  logic [7:0]   prev_data = '0;
  int           hi_len = 0, low_len = 0, frame_strobes = 0;
  bit           frame_rise = 0;
  stb_t         e;
  res_t         r;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_ld = '0; prev_data = data; hi_len = 0; low_len = 0;
      frame_strobes = 0; frame_rise = 0;
    end else begin
      if (in_valid && !in_ready) saw_full = 1;
      if (load_data != '0) begin
        if (prev_ld == '0) begin
          rise_total++;
          rise_times.push_back(cyc);
          if (frame_rise) check_eq("gap_min", 32'(low_len >= int'(GAP + 1)), 1);
          if (exp_q.size() == 0) check_eq("spurious_strobe", 32'(load_data), 0);
          else begin
            e = exp_q.pop_front();
            check_eq("strobe_mask", 32'(load_data), 32'(e.mask));
            check_eq("strobe_data", 32'(data), 32'(e.dat));
          end
          check_eq("data_setup", 32'(prev_data), 32'(data));
          hi_len = 1; frame_rise = 1; frame_strobes++;
        end else begin
          check_eq("strobe_hold", 32'(load_data), 32'(prev_ld));
          check_eq("data_hold", 32'(data), 32'(prev_data));
          hi_len++;
        end
      end else begin
        if (prev_ld != '0) begin
          check_eq("strobe_width", 32'(hi_len), STB);
          low_len = 0;
        end
        low_len++;
      end
      if (frame_done || frame_err) begin
        if (exp_res.size() == 0) check_eq("spurious_frame_end", 32'({frame_done, frame_err}), 0);
        else begin
          r = exp_res.pop_front();
          check_eq("frame_kind", 32'({frame_done, frame_err}), r.err ? 32'h1 : 32'h2);
          check_eq("frame_strobes", 32'(frame_strobes), 32'(r.n));
        end
        frame_strobes = 0; frame_rise = 0;
      end
      prev_ld = load_data; prev_data = data;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) check_eq("push_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Model: derive expected strobes and outcome from the frame in frm, then push it
  task automatic send_frame(input int gap_max, input int hdr_stall);
    logic [7:0]   id;
    logic [N-1:0] one = 1;
    stb_t         s;
    res_t         rr;
    bit           good, stall_bad;
    id   = frm[0];
    good = (int'(id) < int'(N)) || (id == 8'hFF);
    rr.n = 0;
    if (good) begin
      for (int i = 0; i < int'(frm[1]); i++) begin
        s.mask = (id == 8'hFF) ? '1 : (one << id);
        s.dat  = frm[2 + i];
        exp_q.push_back(s);
        rr.n++;
      end
    end
    rr.err = !good;
    exp_res.push_back(rr);
    for (int i = 0; i < frm.size(); i++) begin
      push_byte(frm[i]);
      if (i == 1 && hdr_stall > 0) begin
        stall_bad = 0;
        repeat (hdr_stall) begin
          @(posedge clk); #1;
          if (load_data != '0) stall_bad = 1;
        end
        check_eq("stall_strobe_low", 32'(stall_bad), 0);
        check_eq("stall_busy", 32'(busy), 1);
      end else if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_res.size() != 0 || busy) && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    check_eq("drain", 32'(exp_res.size() != 0 || busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_load"}, 32'(load_data), 0);
    check_eq({tag, "_data"}, 32'(data), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(frame_done), 0);
    check_eq({tag, "_err"}, 32'(frame_err), 0);
    check_eq({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, k;
    logic [7:0] id;
    int sel, len;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Unicast frame, back-to-back bytes: period STB+GAP+1 per byte
    frm = '{8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    rise_times.delete();
    send_frame(0, 0);
    wait_idle();
    check_eq("t1_rises", 32'(rise_times.size()), 3);
    if (rise_times.size() == 3) begin
      check_eq("t1_period0", 32'(rise_times[1] - rise_times[0]), STB + GAP + 1);
      check_eq("t1_period1", 32'(rise_times[2] - rise_times[1]), STB + GAP + 1);
    end

    // Broadcast
    frm = '{8'hFF, 8'h01, 8'h5A};
    send_frame(0, 0);
    wait_idle();

    // Invalid ID drained, then a normal frame
    frm = '{8'h09, 8'h02, 8'h11, 8'h22};
    send_frame(0, 0);
    frm = '{8'h00, 8'h01, 8'h77};
    send_frame(0, 0);
    wait_idle();

    // Overfill the FIFO with back-to-back frames
    saw_full = 0;
    frm = '{8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(0, 0);
    frm = '{8'h01, 8'h02, 8'h50, 8'h60};
    send_frame(0, 0);
    wait_idle();
    check_eq("t4_in_ready_dropped", 32'(saw_full), 1);

    // Reset during the second strobe of a 3-byte frame
    base = rise_total;
    frm = '{8'h01, 8'h03, 8'h3C, 8'hC3, 8'h96};
    send_frame(0, 0);
    k = 0;
    while (rise_total < base + 2 && k < 200) begin
      @(negedge clk); #1; k++;
    end
    check_eq("t5_reached_2nd_strobe", 32'(rise_total >= base + 2), 1);
    rst = 1'b1;
    exp_q.delete();
    exp_res.delete();
    @(posedge clk); #1;
    check_reset_outputs("t5_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("t5_fifo_flushed_busy", 32'(busy), 0);
    check_eq("t5_no_strobe", 32'(load_data), 0);
    frm = '{8'h02, 8'h02, 8'hE1, 8'h1E};
    send_frame(1, 0);
    wait_idle();

    // Zero-length frame completes quickly
    frm = '{8'h01, 8'h00};
    send_frame(0, 0);
    k = 0;
    while (!frame_done && k < 6) begin
      @(posedge clk); #1; k++;
    end
    check_eq("t6_len0_latency", 32'(k <= 3), 1);
    wait_idle();

    // Late payload stalls in LOAD with strobes low
    frm = '{8'h03, 8'h02, 8'hA5, 8'h5A};
    send_frame(0, 20);
    wait_idle();

    // Randomized frames with random host gaps
    for (int f = 0; f < 25; f++) begin
      sel = $urandom_range(3, 0);
      if (sel < 2)       id = 8'($urandom_range(N - 1, 0));
      else if (sel == 2) id = 8'hFF;
      else               id = 8'($urandom_range(254, N));
      len = $urandom_range(4, 0);
      frm.delete();
      frm.push_back(id);
      frm.push_back(8'(len));
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(255, 0)));
      send_frame($urandom_range(3, 0), 0);
    end
    wait_idle();
    check_eq("final_no_pending_strobes", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
